// File: rtl/qdec_cabac_reg_master.sv
// qdec_cabac_reg_master: writes the five CABAC parameter registers (optionally reading each back),
// then writes START=1; one bus transaction outstanding, reports done or err with code/index.
module qdec_cabac_reg_master #(
  parameter logic [15:0] ADDR_START     = 16'h0000,
  parameter logic [15:0] ADDR_VPS_0     = 16'h0004,
  parameter logic [15:0] ADDR_SPS_0     = 16'h0008,
  parameter logic [15:0] ADDR_SPS_1     = 16'h000C,
  parameter logic [15:0] ADDR_PPS_0     = 16'h0010,
  parameter logic [15:0] ADDR_SH_0      = 16'h0014,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_verify,
  input  logic [31:0] cfg_vps0,
  input  logic [31:0] cfg_sps0,
  input  logic [31:0] cfg_sps1,
  input  logic [31:0] cfg_pps0,
  input  logic [31:0] cfg_sh0,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [15:0] req_addr,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  input  logic        rsp_err,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [2:0]  err_idx
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] AT [6] = '{ADDR_VPS_0, ADDR_SPS_0, ADDR_SPS_1, ADDR_PPS_0, ADDR_SH_0, ADDR_START};
  localparam logic [31:0] MSK [5] = '{32'h0000000F, 32'h0FFFFFFF, 32'h07FFFFFF, 32'h0000FFFF, 32'h0000FFFF};
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, ST_REQ, ST_RSP} state_t;
  state_t        state_q;
  logic [31:0]   w_q [5];
  logic [31:0]   wd [6];
  logic [31:0]   cw [5];
  logic [2:0]    idx_q, nidx, err_idx_q;
  logic [TW-1:0] tmo_q;
  logic          verify_q, req_valid_q, req_write_q, done_q, err_q, bad;
  logic [15:0]   req_addr_q;
  logic [31:0]   req_wdata_q;
  logic [1:0]    err_code_q;
  // wd[5] is the START payload so the advance path can index it like a parameter word
  always_comb begin
    for (int i = 0; i < 5; i++) wd[i] = w_q[i];
    wd[5] = 32'h1;
    cw = '{cfg_vps0, cfg_sps0, cfg_sps1, cfg_pps0, cfg_sh0};
    nidx = idx_q + 3'd1;
    bad = rsp_err || (state_q == RD_RSP && rsp_rdata != wd[idx_q]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q <= '0;
      req_wdata_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err_code_q <= '0;
      err_idx_q <= '0;
      idx_q <= '0;
      tmo_q <= '0;
      verify_q <= 1'b0;
      for (int i = 0; i < 5; i++) w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (cfg_valid) begin
          for (int i = 0; i < 5; i++) w_q[i] <= cw[i] & MSK[i];
          verify_q <= cfg_verify;
          err_code_q <= '0;
          err_idx_q <= '0;
          idx_q <= '0;
          req_valid_q <= 1'b1;
          req_write_q <= 1'b1;
          req_addr_q <= ADDR_VPS_0;
          req_wdata_q <= cfg_vps0 & MSK[0];
          state_q <= WR_REQ;
        end
        WR_REQ, RD_REQ, ST_REQ: if (req_ready) begin
          req_valid_q <= 1'b0;
          req_write_q <= 1'b0;
          req_addr_q <= '0;
          req_wdata_q <= '0;
          tmo_q <= '0;
          state_q <= state_q == WR_REQ ? WR_RSP : state_q == RD_REQ ? RD_RSP : ST_RSP;
        end
        default: if (rsp_valid) begin
          if (bad) begin
            err_q <= 1'b1;
            err_code_q <= rsp_err ? 2'd1 : 2'd3;
            err_idx_q <= idx_q;
            state_q <= IDLE;
          end else if (state_q == WR_RSP && verify_q) begin
            req_valid_q <= 1'b1;
            req_write_q <= 1'b0;
            req_addr_q <= AT[idx_q];
            req_wdata_q <= '0;
            state_q <= RD_REQ;
          end else if (state_q == ST_RSP) begin
            done_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q <= nidx;
            req_valid_q <= 1'b1;
            req_write_q <= 1'b1;
            req_addr_q <= AT[nidx];
            req_wdata_q <= wd[nidx];
            state_q <= idx_q == 3'd4 ? ST_REQ : WR_REQ;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_q <= 1'b1;
          err_code_q <= 2'd2;
          err_idx_q <= idx_q;
          state_q <= IDLE;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      endcase
    end
  end
  assign cfg_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign req_valid = req_valid_q;
  assign req_write = req_write_q;
  assign req_addr = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign done = done_q;
  assign err = err_q;
  assign err_code = err_code_q;
  assign err_idx = err_idx_q;
endmodule

// File: doc/qdec_cabac_reg_master.md
# qdec_cabac_reg_master

Register-bus initiator that programs the CABAC decoder parameter registers and then writes the start register. It is the write side of the CABAC register interface. It takes one parameter set from the header parser through a valid/ready handshake and issues five parameter writes in fixed order: VPS_0, SPS_0, SPS_1, PPS_0, SLICE_HEADER_0. If enabled, it reads each register back and checks it against the field mask. It finishes with START=1 and reports done or error; one bus transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_START, 16'h0000, address of CABAC_START
- ADDR_VPS_0, 16'h0004, address of CABAC_VPS_0
- ADDR_SPS_0, 16'h0008, address of CABAC_SPS_0
- ADDR_SPS_1, 16'h000C, address of CABAC_SPS_1
- ADDR_PPS_0, 16'h0010, address of CABAC_PPS_0
- ADDR_SH_0, 16'h0014, address of CABAC_SLICE_HEADER_0
- TIMEOUT_CYCLES, 64, maximum response wait in cycles; must be ≥2; counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_valid  in  1  parameter set offered
- cfg_ready  out  1  block idle and accepting
- cfg_verify  in  1  enable read-back verification
- cfg_vps0, cfg_sps0, cfg_sps1, cfg_pps0, cfg_sh0  in  32 each  register values
- req_valid  out  1  bus request
- req_ready  in  1  request accepted
- req_write  out  1  1 = write, 0 = read
- req_addr  out  16  request address
- req_wdata  out  32  write data; 0 on reads
- rsp_valid  in  1  response strobe
- rsp_rdata  in  32  read data
- rsp_err  in  1  bus error on the response
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on abort
- err_code  out  2  0 none, 1 bus error, 2 timeout, 3 read-back mismatch; held until next accept
- err_idx  out  3  register index of the failure (0 VPS … 4 SH, 5 START); held

## Operation
- States: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, ST_REQ, ST_RSP.
- IDLE: cfg_ready=1. A handshake (cfg_valid & cfg_ready) does the following:
  - latches the five words and verify into internal registers;
  - clears err_code/err_idx;
  - sets idx=0 and goes to WR_REQ.
- WR_REQ: request is write, addr/data for idx. Data is the latched word ANDed with its mask:
  - VPS 0x0000000F
  - SPS_0 0x0FFFFFFF
  - SPS_1 0x07FFFFFF
  - PPS 0x0000FFFF
  - SH 0x0000FFFF
- On req_ready, WR_REQ → WR_RSP.
- WR_RSP: on rsp_valid:
  - rsp_err → abort with code 1;
  - else if verify → RD_REQ (same idx);
  - else if idx==4 → ST_REQ;
  - else idx++ and → WR_REQ.
- RD_REQ: read at the same address. On req_ready → RD_RSP.
- RD_RSP: on rsp_valid:
  - rsp_err → code 1;
  - rsp_rdata ≠ masked write data → code 3;
  - else same idx advance rule as WR_RSP.
- ST_REQ: write ADDR_START with data 32'h1. On req_ready → ST_RSP.
- ST_RSP: on rsp_valid:
  - rsp_err → code 1 (idx 5);
  - else pulse done and → IDLE.
- Timeout: the counter clears on entry to each *_RSP state and increments each cycle without rsp_valid. Reaching TIMEOUT_CYCLES aborts with code 2.
- Abort:
  - pulse err, set err_idx=idx and go to IDLE;
  - START is never written after an abort.
- busy = (state ≠ IDLE).
- rsp_valid outside *_RSP states is ignored.
- The cfg_* inputs are ignored while busy.

## Timing
- Reset values:
  - state IDLE, req_valid 0, req_write 0, req_addr 0, req_wdata 0;
  - busy 0, done 0, err 0, err_code 0, err_idx 0, counters 0;
  - cfg_ready 1 from the first cycle after reset.
- req_valid/req_addr/req_wdata/req_write are registered. They stay stable while req_valid=1 and req_ready=0, and drop to 0 the cycle after acceptance.
- The earliest rsp_valid is the cycle after request acceptance. rsp_valid in the acceptance cycle itself is ignored.
- Latency, with cfg handshake at T, req_ready=1 and the response one cycle after acceptance:
  - each transaction takes 2 cycles, and the first req_valid is at T+1;
  - no verify: 6 transactions, done at T+13;
  - verify: 11 transactions, done at T+23.
- done/err are registered pulses, the cycle after the final response or the timeout.
- cfg_ready returns in the same cycle as done/err, so back-to-back sets are possible.
- Reset mid-sequence returns to IDLE next cycle with req_valid=0. The outstanding transaction is abandoned and its late response is ignored.

## Test plan
- No verify, req_ready=1, 1-cycle response; cfg VPS=0xFFFFFFFF, SPS_0=0xFFFFFFFF, SPS_1=0xFFFFFFFF, PPS=0x12345678, SH=0xABCD1234 → expected:
  - 6 writes in order with data 0xF, 0x0FFFFFFF, 0x07FFFFFF, 0x5678, 0x1234, then 0x1 to ADDR_START;
  - done at T+13, err_code 0.
- Verify on, slave memory model returns the written data → writes and reads interleave (11 transactions), done at T+23.
- Verify on, slave corrupts the SPS_1 read-back (returns 0x0) → err pulse, err_code 3, err_idx 2; no START write; cfg_ready 1.
- req_ready held low 5 cycles on the first write → request fields stable for all 5 cycles, no duplicate request; completion delayed by exactly 5 cycles.
- No response to the PPS write → err after TIMEOUT_CYCLES (64) cycles in WR_RSP, err_code 2, err_idx 3; a later rsp_valid in IDLE has no effect.
- rsp_err on the START write gives err_code 1, err_idx 5, and no done pulse. Separately, rst_n asserted in WR_RSP gives all outputs at reset values next cycle, and a new set is then accepted normally.
